// File: rtl/sram_arbiter.sv
// Purpose : arbitrates IFU (read-only) and LSU (read/write) requests onto one SRAM port,
//           with a single transaction in flight.
// Latency : read turnaround is 3+RD_LAT cycles from handshake to IDLE; write turnaround is 3 cycles.
// Backpr. : req_ready is asserted only in IDLE, and only for the winner. RESP holds rsp_valid and rdata
//           until the owner's rsp_ready; no new request is accepted meanwhile.
//
// Ports:
//   clock, reset         sole clock; asynchronous active-high reset
//   ifu_req_*/ifu_addr   IFU read request (valid/ready)
//   ifu_rsp_*/ifu_rdata  IFU read response (valid/ready)
//   lsu_req_*/lsu_wen/lsu_addr/lsu_wdata/lsu_wstrb   LSU request; wen=1 is a write
//   lsu_rsp_*/lsu_rdata  LSU response; rdata is 0 for writes
//   mem_read/mem_r_*     one-cycle read pulse; data returns RD_LAT cycles later on mem_r_data
//   mem_write/mem_w_*    one-cycle write pulse with address, data and byte strobe
//
// Parameter RD_LAT (1..7): cycles from the mem_read pulse to valid mem_r_data.
// Optional build macro SRAM_ARB_ROUND_ROBIN_EN: round-robin arbitration between simultaneous
// requesters. When the macro is absent, the LSU always has priority over the IFU.
module sram_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  // IFU request / response
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rdata,
  // LSU request / response
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [31:0] lsu_rdata,
  // memory side
  output logic        mem_read,
  output logic [31:0] mem_r_addr,
  input  logic [31:0] mem_r_data,
  output logic        mem_write,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [3:0]  mem_w_strb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The last WAIT count is the cycle where mem_r_data is valid.
  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wait_cnt;

  // Latched transaction
  logic        owner_lsu;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // Per-requester response data
  logic [31:0] ifu_rdata_q;
  logic [31:0] lsu_rdata_q;

  logic        grant_lsu;
  logic        accept;
  logic        hs_ifu;
  logic        hs_lsu;
  logic        hs;
  logic        strb_ok;
  logic        wait_done;
  logic        owner_rsp_ready;

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // When set, the LSU wins a simultaneous request. After each handshake, the pointer
  // moves to favour the requester that was not just served.
  logic rr_lsu_pri;

  assign grant_lsu = lsu_req_valid & (rr_lsu_pri | ~ifu_req_valid);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_lsu_pri <= 1'b1;
    end else if (hs) begin
      rr_lsu_pri <= hs_ifu;
    end
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  // Ready is gated by reset so that every output is 0 while reset is asserted,
  // even though the IDLE readies depend combinationally on the valid inputs.
  assign accept        = (state == IDLE) & ~reset;
  assign lsu_req_ready = accept & grant_lsu;
  assign ifu_req_ready = accept & ifu_req_valid & ~grant_lsu;

  assign hs_lsu = lsu_req_valid & lsu_req_ready;
  assign hs_ifu = ifu_req_valid & ifu_req_ready;
  assign hs     = hs_lsu | hs_ifu;

  // Only byte, halfword and word strobes are supported. Any other pattern is
  // dropped on the memory side but still receives a response.
  assign strb_ok = (wstrb_q == 4'b0001) || (wstrb_q == 4'b0011) || (wstrb_q == 4'b1111);

  assign wait_done       = (wait_cnt == LAST_CNT);
  assign owner_rsp_ready = owner_lsu ? lsu_rsp_ready : ifu_rsp_ready;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hs) state_nxt = ISSUE;
      ISSUE: state_nxt = wen_q ? RESP : WAIT;
      WAIT:  if (wait_done) state_nxt = RESP;
      RESP:  if (owner_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // WAIT counter: it restarts from 0 every time WAIT is entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 3'd0;
    end else if (state == WAIT && !wait_done) begin
      wait_cnt <= wait_cnt + 3'd1;
    end else begin
      wait_cnt <= 3'd0;
    end
  end

  // ------------------------------------------------------------------
  // Request latch. IFU requests are reads, so wen, wdata and wstrb are zeroed.
  // This also keeps mem_w_data and mem_w_strb at 0 during reads.
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_lsu <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else if (hs) begin
      owner_lsu <= hs_lsu;
      wen_q     <= hs_lsu & lsu_wen;
      addr_q    <= hs_lsu ? lsu_addr : ifu_addr;
      wdata_q   <= (hs_lsu & lsu_wen) ? lsu_wdata : 32'd0;
      wstrb_q   <= (hs_lsu & lsu_wen) ? lsu_wstrb : 4'd0;
    end
  end

  // ------------------------------------------------------------------
  // Response data. Reads capture on the last WAIT count. Writes clear the
  // owner's register during ISSUE, so that RESP returns 0.
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifu_rdata_q <= 32'd0;
      lsu_rdata_q <= 32'd0;
    end else if (state == WAIT && wait_done) begin
      if (owner_lsu) lsu_rdata_q <= mem_r_data;
      else           ifu_rdata_q <= mem_r_data;
    end else if (state == ISSUE && wen_q) begin
      if (owner_lsu) lsu_rdata_q <= 32'd0;
      else           ifu_rdata_q <= 32'd0;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign ifu_rsp_valid = (state == RESP) & ~owner_lsu;
  assign lsu_rsp_valid = (state == RESP) &  owner_lsu;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

  // Pulses exist only in ISSUE. Because wen_q selects exactly one of them,
  // read and write can never be high together.
  assign mem_read   = (state == ISSUE) & ~wen_q;
  assign mem_write  = (state == ISSUE) &  wen_q & strb_ok;
  assign mem_r_addr = addr_q;
  assign mem_w_addr = addr_q;
  assign mem_w_data = wdata_q;
  assign mem_w_strb = wstrb_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (RD_LAT=1): reset state, IFU/LSU reads and writes,
// illegal strobe, arbitration, response back-pressure and reset during WAIT.
module tb_sram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_r_addr, mem_r_data, mem_w_addr, mem_w_data;
  logic [3:0]  mem_w_strb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sram_arbiter #(.RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .mem_read(mem_read), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_write(mem_write), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_strb(mem_w_strb)
  );

  // Memory model with one-cycle read latency. Data is valid only in the cycle
  // after the pulse; every other cycle returns a poison word.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_5A5A);
  endfunction

  always @(posedge clock) mem_r_data <= mem_read ? mem_val(mem_r_addr) : 32'hBAD0_BAD0;

  // Pulse / protocol monitor, sampled mid-cycle.
  int rd_pulses = 0, wr_pulses = 0, both_hi = 0, rd_dirty = 0, dual_rsp = 0;
  logic [31:0] last_rd_addr = '0, last_w_addr = '0, last_w_data = '0;
  logic [3:0]  last_w_strb = '0;

  always @(negedge clock) begin
    if (mem_read) begin
      rd_pulses++;
      last_rd_addr = mem_r_addr;
      if (mem_w_data != 32'd0 || mem_w_strb != 4'd0) rd_dirty++;
    end
    if (mem_write) begin
      wr_pulses++;
      last_w_addr = mem_w_addr;
      last_w_data = mem_w_data;
      last_w_strb = mem_w_strb;
    end
    if (mem_read && mem_write) both_hi++;
    if (ifu_rsp_valid && lsu_rsp_valid) dual_rsp++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and waits for its response (rsp_ready is held at 1).
  // Turnaround is measured from the handshake edge to the IDLE re-entry edge.
  task automatic run_txn(input string tag, input bit is_lsu, input bit wen,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rdata,
                         input int exp_turn);
    int n;
    bit got;
    if (is_lsu) begin
      lsu_req_valid = 1'b1; lsu_wen = wen; lsu_addr = addr;
      lsu_wdata = wdata; lsu_wstrb = strb;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (is_lsu ? lsu_req_ready : ifu_req_ready) got = 1'b1;
      else begin tick(); #1; end
    end
    chk({tag, "_accept"}, 32'(got), 32'd1);
    if (!got) begin
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      return;
    end
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    n = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (is_lsu ? lsu_rsp_valid : ifu_rsp_valid) got = 1'b1;
      else begin tick(); n++; end
    end
    chk({tag, "_rsp"}, 32'(got), 32'd1);
    if (!got) return;
    chk({tag, "_rdata"}, is_lsu ? lsu_rdata : ifu_rdata, exp_rdata);
    chk({tag, "_other_vld"}, 32'(is_lsu ? ifu_rsp_valid : lsu_rsp_valid), 32'd0);
    tick();
    n++;
    #1;
    chk({tag, "_turn"}, 32'(n), 32'(exp_turn));
    chk({tag, "_rsp_drop"}, 32'(is_lsu ? lsu_rsp_valid : ifu_rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp, wp;
    logic [3:0] exp_lsu;
    bit w;
    reset = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h1234_5678; ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h1111_2222;
    lsu_wdata = 32'h3333_4444; lsu_wstrb = 4'b1111; lsu_rsp_ready = 1'b1;

    // Reset state with both requesters valid
    tick(); tick(); #1;
    chk("rst_ifu_rdy",  32'(ifu_req_ready), 32'd0);
    chk("rst_lsu_rdy",  32'(lsu_req_ready), 32'd0);
    chk("rst_ifu_vld",  32'(ifu_rsp_valid), 32'd0);
    chk("rst_lsu_vld",  32'(lsu_rsp_valid), 32'd0);
    chk("rst_ifu_data", ifu_rdata, 32'd0);
    chk("rst_lsu_data", lsu_rdata, 32'd0);
    chk("rst_mem_rd",   32'(mem_read),  32'd0);
    chk("rst_mem_wr",   32'(mem_write), 32'd0);
    chk("rst_r_addr",   mem_r_addr, 32'd0);
    chk("rst_w_addr",   mem_w_addr, 32'd0);
    chk("rst_w_data",   mem_w_data, 32'd0);
    chk("rst_w_strb",   32'(mem_w_strb), 32'd0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // IFU read of the boot vector
    rp = rd_pulses; wp = wr_pulses;
    run_txn("ifu_rd", 1'b0, 1'b0, 32'h8000_0000, 32'd0, 4'd0, 32'h0000_0413, 4);
    chk("ifu_rd_pulses", 32'(rd_pulses - rp), 32'd1);
    chk("ifu_rd_addr",   last_rd_addr, 32'h8000_0000);
    chk("ifu_rd_nowr",   32'(wr_pulses - wp), 32'd0);

    // LSU halfword write
    rp = rd_pulses; wp = wr_pulses;
    run_txn("lsu_wr", 1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 32'd0, 3);
    chk("lsu_wr_pulses", 32'(wr_pulses - wp), 32'd1);
    chk("lsu_wr_nord",   32'(rd_pulses - rp), 32'd0);
    chk("lsu_wr_strb",   32'(last_w_strb), 32'h3);
    chk("lsu_wr_addr",   last_w_addr, 32'h8000_0100);
    chk("lsu_wr_data",   last_w_data, 32'hDEAD_BEEF);

    // Illegal strobe: no memory write, but a response is still given
    wp = wr_pulses;
    run_txn("bad_strb", 1'b1, 1'b1, 32'h8000_0200, 32'hCAFE_F00D, 4'b0101, 32'd0, 3);
    chk("bad_strb_nowr", 32'(wr_pulses - wp), 32'd0);

    // Byte and word writes are legal
    wp = wr_pulses;
    run_txn("wr_byte", 1'b1, 1'b1, 32'h0000_0040, 32'h0000_00AB, 4'b0001, 32'd0, 3);
    chk("wr_byte_strb", 32'(last_w_strb), 32'h1);
    run_txn("wr_word", 1'b1, 1'b1, 32'h0000_0044, 32'h0102_0304, 4'b1111, 32'd0, 3);
    chk("wr_word_pulses", 32'(wr_pulses - wp), 32'd2);

    // LSU read after a write: the data/strobe buses must be clean
    rp = rd_pulses;
    run_txn("lsu_rd", 1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'hA5A5_4A5A, 4);
    chk("lsu_rd_pulses", 32'(rd_pulses - rp), 32'd1);
    chk("lsu_rd_addr",   last_rd_addr, 32'h0000_1000);

    // IFU response back-pressure for 10 cycles while the LSU is requesting
    ifu_rsp_ready = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_2000;
    #1;
    chk("bp_accept", 32'(ifu_req_ready), 32'd1);
    tick(); ifu_req_valid = 1'b0;
    tick(); tick(); #1;
    chk("bp_vld0",  32'(ifu_rsp_valid), 32'd1);
    chk("bp_data0", ifu_rdata, 32'hA5A5_7A5A);
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_3000;
    rp = rd_pulses; wp = wr_pulses;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("bp_vld",     32'(ifu_rsp_valid), 32'd1);
      chk("bp_data",    ifu_rdata, 32'hA5A5_7A5A);
      chk("bp_lsu_rdy", 32'(lsu_req_ready), 32'd0);
    end
    chk("bp_no_pulse", 32'((rd_pulses - rp) + (wr_pulses - wp)), 32'd0);
    ifu_rsp_ready = 1'b1; lsu_req_valid = 1'b0;
    tick(); #1;
    chk("bp_release", 32'(ifu_rsp_valid), 32'd0);

    // Reset asserted during WAIT
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    tick(); ifu_req_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rstw_rsp_vld", 32'(ifu_rsp_valid), 32'd0);
    chk("rstw_mem_rd",  32'(mem_read), 32'd0);
    chk("rstw_rdata",   ifu_rdata, 32'd0);
    chk("rstw_r_addr",  mem_r_addr, 32'd0);
    rp = rd_pulses;
    tick(); tick();
    reset = 1'b0;
    w = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      if (ifu_rsp_valid || lsu_rsp_valid) w = 1'b1;
    end
    chk("rstw_no_rsp", 32'(w), 32'd0);
    chk("rstw_no_pulse", 32'(rd_pulses - rp), 32'd0);
    run_txn("rstw_after", 1'b0, 1'b0, 32'h8000_0000, 32'd0, 4'd0, 32'h0000_0413, 4);

    // Simultaneous requests held for four transactions, starting from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_lsu = 4'b0101;
`else
    exp_lsu = 4'b1111;
`endif
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_4000;
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h0000_5000;
    lsu_wdata = 32'h0000_1234; lsu_wstrb = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bit got;
      #1;
      chk("arb_onehot", 32'(ifu_req_ready) + 32'(lsu_req_ready), 32'd1);
      chk("arb_grant",  32'(lsu_req_ready), 32'(exp_lsu[k]));
      w = lsu_req_ready;
      tick();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        #1;
        if (w ? lsu_rsp_valid : ifu_rsp_valid) got = 1'b1;
        else tick();
      end
      chk("arb_rsp", 32'(got), 32'd1);
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick(); tick();

    chk("never_both_pulses", 32'(both_hi),  32'd0);
    chk("never_dual_rsp",    32'(dual_rsp), 32'd0);
    chk("read_bus_clean",    32'(rd_dirty), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning the cycles from the memory read pulse to valid mem_r_data; legal range is 1..7.
REQ-002 SHALL have ports clock (in, 1, sole clock) and reset (in, 1, asynchronous active-high reset), in that order and first.
REQ-003 SHALL have IFU request ports: ifu_req_valid in 1; ifu_req_ready out 1; ifu_addr in 32 (read-only requester).
REQ-004 SHALL have IFU response ports: ifu_rsp_valid out 1; ifu_rsp_ready in 1; ifu_rdata out 32.
REQ-005 SHALL have LSU request ports: lsu_req_valid in 1; lsu_req_ready out 1; lsu_wen in 1 (1 = write); lsu_addr in 32; lsu_wdata in 32; lsu_wstrb in 4.
REQ-006 SHALL have LSU response ports: lsu_rsp_valid out 1; lsu_rsp_ready in 1; lsu_rdata out 32.
REQ-007 SHALL have memory-side ports: mem_read out 1; mem_r_addr out 32; mem_r_data in 32; mem_write out 1; mem_w_addr out 32; mem_w_data out 32; mem_w_strb out 4.

Function
REQ-008 SHALL use FSM states IDLE, ISSUE, WAIT and RESP, and SHALL hold exactly one transaction in flight.
REQ-009 In IDLE with at least one valid request, the block SHALL assert req_ready of the arbitration winner only (combinational); the loser's ready SHALL be 0.
REQ-010 A handshake (valid & ready) SHALL latch the address, wen, wdata, wstrb and owner, and SHALL move the FSM IDLE->ISSUE.
REQ-011 In ISSUE, the block SHALL pulse mem_read (reads) or mem_write (writes) for exactly one cycle with the latched address, data and strobe.
REQ-012 After a read ISSUE, the FSM SHALL enter WAIT, count RD_LAT cycles, capture mem_r_data into the owner's rdata register on the final count, and then go to RESP.
REQ-013 After a write ISSUE, the FSM SHALL go directly to RESP; the write response rdata SHALL be 0.
REQ-014 For a write, when lsu_wstrb is not one of 0001, 0011 or 1111, the block SHALL suppress mem_write in ISSUE and still give a response (no hang).
REQ-015 In RESP, the block SHALL hold the owner's rsp_valid high with stable rdata until the owner's rsp_ready=1, then go to IDLE; back-pressure of any length SHALL be honoured.
REQ-016 The non-owner's rsp_valid SHALL stay 0 at all times.
REQ-017 mem_read and mem_write SHALL never be high in the same cycle, and SHALL be 0 outside ISSUE.
REQ-018 The minimum read turnaround SHALL be 3+RD_LAT cycles from the request handshake to the IDLE re-entry cycle.
REQ-019 The minimum write turnaround SHALL be 3 cycles from the request handshake to the IDLE re-entry cycle.
REQ-020 mem_r_addr and mem_w_addr SHALL both carry the latched address; mem_w_data and mem_w_strb SHALL be 0 during reads.

Reset
REQ-021 While reset=1, the FSM SHALL be IDLE, the WAIT counter 0, all latched fields 0 and the round-robin pointer set to favour the LSU.
REQ-022 While reset=1, every output SHALL be 0: all req_ready, all rsp_valid, all rdata, mem_read, mem_write and all mem_* buses.
REQ-023 Reset asserted in any state SHALL abandon the transaction with no response and no further memory pulse.
REQ-024 After reset deasserts, operation SHALL resume from IDLE on the next clock edge.

Configuration
REQ-025 With macro SRAM_ARB_ROUND_ROBIN_EN defined, arbitration on simultaneous requests SHALL be round-robin: the requester not granted last wins, and the pointer SHALL update on each request handshake.
REQ-026 With SRAM_ARB_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority LSU over IFU, and the pointer logic SHALL be absent.

Verification
REQ-027 Scenario: IFU read of 0x8000_0000, memory returns 0x0000_0413, RD_LAT=1 -> one mem_read pulse with r_addr 0x8000_0000, then ifu_rsp_valid with ifu_rdata 0x0000_0413, 4 cycles from handshake to IDLE.
REQ-028 Scenario: LSU write addr 0x8000_0100, data 0xDEAD_BEEF, strb 0011 -> one mem_write pulse with strb 0011, then lsu_rsp_valid with rdata 0, and no mem_read.
REQ-029 Scenario: IFU and LSU valid in the same cycle, held for 4 transactions -> with macro, grants alternate LSU,IFU,LSU,IFU; without macro, the LSU wins every time.
REQ-030 Scenario: LSU write with strb 0101 -> mem_write stays 0 throughout, and lsu_rsp_valid still asserts.
REQ-031 Scenario: hold ifu_rsp_ready=0 for 10 cycles in RESP -> ifu_rdata stable, no new request accepted, no mem pulses.
REQ-032 Scenario: assert reset during WAIT -> all outputs 0 immediately, no rsp_valid afterwards, and the next request is served normally.
